// File: rtl/jpeg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jpeg_pkg: shared types and constants for the JPEG front end.  Rev 1.0
// ---------------------------------------------------------------------------
package jpeg_pkg;
  localparam int BLK_SIZE   = 8;
  localparam int DCT_DATA_W = 10;

  typedef struct packed {
    logic [DCT_DATA_W-1:0] data;
    logic                  valid;
  } dctPort_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;
endpackage
`default_nettype wire

// File: rtl/stripe_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stripe_ram: simple dual-port RAM, one write and one registered read port.  Rev 1.0
// ---------------------------------------------------------------------------
module stripe_ram #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 1024,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/raster_to_block.sv
`default_nettype none
// ---------------------------------------------------------------------------
// raster_to_block: double-buffered 8-line stripe store, raster in, 8x8 blocks out.  Rev 1.0
// ---------------------------------------------------------------------------
module raster_to_block
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 10,  // must equal DCT_DATA_W
  parameter int IMG_WIDTH  = 640
) (
  input  logic           clk,
  input  logic           rst_n,
  input  dctPort_t [2:0] in,
  input  logic           sof,
  output dctPort_t [2:0] out,
  output logic           blk_first,
  output logic           blk_last
);
  localparam int STRIPE = BLK_SIZE * IMG_WIDTH;
  localparam int SW     = $clog2(STRIPE);
  localparam int AW     = SW + 1;
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int NBLK   = IMG_WIDTH / BLK_SIZE;
  localparam int BW     = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [SW-1:0] ROW_STRIDE = SW'(IMG_WIDTH);
  localparam logic [SW-1:0] BLK_STRIDE = SW'(BLK_SIZE);
  localparam logic [2:0]    LAST_ROW   = 3'(BLK_SIZE - 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(IMG_WIDTH - 1);
  localparam logic [BW-1:0] LAST_BLK   = BW'(NBLK - 1);

  logic [CW-1:0] wr_col_q;
  logic [2:0]    wr_row_q;
  logic          wr_bank_q;
  logic [1:0]    full_q, full_d;

  rd_state_e     rd_state_q;
  logic          rd_bank_q;
  logic [2:0]    rc_q, rr_q;
  logic [BW-1:0] rb_q;
  logic          out_vld_q, blk_first_q, blk_last_q;

  logic                  w_accept, w_wr_last, w_wr_done, w_rd_last, w_rd_en;
  logic [SW-1:0]         w_wr_off, w_rd_off;
  logic [AW-1:0]         w_waddr, w_raddr;
  logic [DATA_WIDTH-1:0] w_rdata [3];

  assign w_accept  = in[0].valid & in[1].valid & in[2].valid;
  assign w_wr_last = (wr_row_q == LAST_ROW) && (wr_col_q == LAST_COL);
  assign w_wr_done = w_accept && !sof && w_wr_last;
  // A sof pixel always lands at (0,0) of the current bank, dropping any partial stripe.
  assign w_wr_off  = sof ? '0 : SW'(wr_row_q) * ROW_STRIDE + SW'(wr_col_q);
  assign w_waddr   = {wr_bank_q, w_wr_off};

  assign w_rd_en   = (rd_state_q == RD_READ);
  assign w_rd_last = w_rd_en && (rc_q == LAST_ROW) && (rr_q == LAST_ROW) && (rb_q == LAST_BLK);
  assign w_rd_off  = SW'(rr_q) * ROW_STRIDE + SW'(rb_q) * BLK_STRIDE + SW'(rc_q);
  assign w_raddr   = {rd_bank_q, w_rd_off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_col_q  <= '0;
      wr_row_q  <= '0;
      wr_bank_q <= 1'b0;
    end else if (w_accept) begin
      if (sof) begin
        wr_col_q <= CW'(1);
        wr_row_q <= '0;
      end else if (w_wr_last) begin
        wr_col_q  <= '0;
        wr_row_q  <= '0;
        wr_bank_q <= ~wr_bank_q;
      end else if (wr_col_q == LAST_COL) begin
        wr_col_q <= '0;
        wr_row_q <= wr_row_q + 3'd1;
      end else begin
        wr_col_q <= wr_col_q + CW'(1);
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (w_rd_last) full_d[rd_bank_q] = 1'b0;
    if (w_wr_done) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_q <= '0;
    else        full_q <= full_d;
  end

  // Counters hold the address being read this cycle; flags follow it by the RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rc_q        <= '0;
      rr_q        <= '0;
      rb_q        <= '0;
      out_vld_q   <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      out_vld_q   <= w_rd_en;
      blk_first_q <= w_rd_en && (rc_q == 3'd0) && (rr_q == 3'd0);
      blk_last_q  <= w_rd_en && (rc_q == LAST_ROW) && (rr_q == LAST_ROW);
      case (rd_state_q)
        RD_IDLE: begin
          if (full_q[rd_bank_q]) begin
            rd_state_q <= RD_READ;
            rc_q       <= '0;
            rr_q       <= '0;
            rb_q       <= '0;
          end
        end
        RD_READ: begin
          if (w_rd_last) begin
            rd_bank_q  <= ~rd_bank_q;
            rc_q       <= '0;
            rr_q       <= '0;
            rb_q       <= '0;
            rd_state_q <= full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
          end else if (rc_q == LAST_ROW) begin
            rc_q <= '0;
            if (rr_q == LAST_ROW) begin
              rr_q <= '0;
              rb_q <= rb_q + 1'b1;
            end else begin
              rr_q <= rr_q + 3'd1;
            end
          end else begin
            rc_q <= rc_q + 3'd1;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    stripe_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (2 * STRIPE)
    ) u_ram (
      .clk    (clk),
      .we_i   (w_accept),
      .waddr_i(w_waddr),
      .wdata_i(in[i].data),
      .re_i   (w_rd_en),
      .raddr_i(w_raddr),
      .rdata_o(w_rdata[i])
    );
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      out[i].data  = w_rdata[i];
      out[i].valid = out_vld_q;
    end
  end

  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;
endmodule
`default_nettype wire

// File: tb/tb_raster_to_block.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_raster_to_block: randomized directed scenarios against a stripe/block reference model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_raster_to_block;
  import jpeg_pkg::*;

  localparam int W    = 16;
  localparam int NPIX = 8 * W;

  typedef struct packed {
    int         cyc;
    logic [9:0] y, cb, cr;
    logic       f, l;
  } smp_t;

  typedef struct packed {
    logic [9:0] y, cb, cr;
  } pix_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sof = 1'b0;
  dctPort_t [2:0] din = '0;
  dctPort_t [2:0] dout;
  logic           blk_first, blk_last;

  raster_to_block #(.DATA_WIDTH(10), .IMG_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (din),
    .sof      (sof),
    .out      (dout),
    .blk_first(blk_first),
    .blk_last (blk_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  smp_t obs[$];
  smp_t exp_q[$];
  pix_t acc[$];
  int   next_free = 0;
  int   checks = 0;
  int   passed = 0;
  int   side_bad = 0;

  always @(negedge clk) begin
    if (dout[0].valid === 1'b1)
      obs.push_back('{cyc: cyc, y: dout[0].data, cb: dout[1].data, cr: dout[2].data,
                      f: blk_first, l: blk_last});
    if (rst_n === 1'b1) begin
      if (dout[1].valid !== dout[0].valid || dout[2].valid !== dout[0].valid) side_bad++;
      if (dout[0].valid !== 1'b1 && (blk_first === 1'b1 || blk_last === 1'b1)) side_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: a completed stripe leaves in 8x8 block order, 2 cycles after its last pixel
  // or right after the previous stripe, whichever is later.
  task automatic send(input pix_t p, input logic [2:0] vm, input logic s);
    int start, k;
    pix_t q;
    din[0].data = p.y;  din[0].valid = vm[0];
    din[1].data = p.cb; din[1].valid = vm[1];
    din[2].data = p.cr; din[2].valid = vm[2];
    sof = s;
    tick(1);
    if (vm == 3'b111) begin
      if (s) acc.delete();
      acc.push_back(p);
      if (acc.size() == NPIX) begin
        start = (cyc + 2 > next_free) ? cyc + 2 : next_free;
        k = 0;
        for (int b = 0; b < W / 8; b++)
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
              q = acc[r * W + b * 8 + c];
              exp_q.push_back('{cyc: start + k, y: q.y, cb: q.cb, cr: q.cr,
                                f: (r == 0 && c == 0), l: (r == 7 && c == 7)});
              k++;
            end
        next_free = start + NPIX;
        acc.delete();
      end
    end
  endtask

  task automatic idle();
    din[0].valid = 1'b0; din[1].valid = 1'b0; din[2].valid = 1'b0;
    sof = 1'b0;
  endtask

  function automatic pix_t rnd_pix();
    return '{y: 10'($urandom_range(0, 1023)), cb: 10'($urandom_range(0, 1023)),
             cr: 10'($urandom_range(0, 1023))};
  endfunction

  task automatic drain();
    for (int t = 0; t < 3000 && obs.size() < exp_q.size(); t++) tick(1);
    tick(10);
  endtask

  task automatic compare_all(input string tag);
    smp_t o;
    drain();
    chk({tag, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      o = (k < obs.size()) ? obs[k] : '0;
      chk(tag, o, exp_q[k]);
    end
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    int nf, nl;
    logic [2:0] vm;
    pix_t p;

    // Reset state
    tick(3);
    chk("reset_valid", 64'(dout[0].valid), 64'(0));
    chk("reset_first", 64'(blk_first), 64'(0));
    chk("reset_last", 64'(blk_last), 64'(0));
    rst_n = 1'b1;
    tick(2);

    // Y ramp, Cb=Cr=512, contiguous
    for (int i = 0; i < NPIX; i++)
      send('{y: 10'((i / W) * 16 + (i % W)), cb: 10'd512, cr: 10'd512}, 3'b111, i == 0);
    idle();
    drain();
    chk("ramp_spot8", (obs.size() > 8) ? 64'(obs[8].y) : 64'hdead, 64'd16);
    chk("ramp_spot64", (obs.size() > 64) ? 64'(obs[64].y) : 64'hdead, 64'd8);
    chk("ramp_cb512", (obs.size() > 100) ? 64'(obs[100].cb) : 64'hdead, 64'd512);
    compare_all("ramp");

    // Random data, a stalled cycle before every accepted pixel
    for (int i = 0; i < NPIX; i++) begin
      case ($urandom_range(0, 3))
        0: vm = 3'b000;
        1: vm = 3'b110;
        2: vm = 3'b101;
        default: vm = 3'b011;
      endcase
      send(rnd_pix(), vm, 1'($urandom_range(0, 1)));
      send(rnd_pix(), 3'b111, 1'b0);
    end
    idle();
    compare_all("gappy");

    // Two stripes back-to-back
    for (int i = 0; i < 2 * NPIX; i++) send(rnd_pix(), 3'b111, 1'b0);
    idle();
    drain();
    nf = 0; nl = 0;
    foreach (obs[k]) begin
      if (obs[k].f) nf++;
      if (obs[k].l) nl++;
    end
    chk("b2b_first_pulses", 64'(nf), 64'd4);
    chk("b2b_last_pulses", 64'(nl), 64'd4);
    chk("b2b_span", (obs.size() >= 256) ? 64'(obs[255].cyc - obs[0].cyc) : 64'hdead, 64'd255);
    compare_all("b2b");

    // Full stripe, then sof at pixel 50 of the next one while the first is being read
    for (int i = 0; i < NPIX; i++) send(rnd_pix(), 3'b111, 1'b0);
    for (int i = 0; i < 49; i++) send(rnd_pix(), 3'b111, 1'b0);
    for (int i = 0; i < NPIX; i++) send(rnd_pix(), 3'b111, i == 0);
    idle();
    compare_all("sof");

    // Reset during output sample ~70
    for (int i = 0; i < NPIX; i++) send(rnd_pix(), 3'b111, 1'b0);
    idle();
    for (int t = 0; t < 2000 && obs.size() < 70; t++) tick(1);
    chk("rst_reached70", 64'(obs.size() >= 70), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(dout[0].valid), 64'd0);
    chk("rst_async_last", 64'(blk_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    obs.delete();
    exp_q.delete();
    acc.delete();
    next_free = 0;
    tick(200);
    chk("rst_no_output", 64'(obs.size()), 64'd0);
    for (int i = 0; i < NPIX; i++) begin
      p = rnd_pix();
      send(p, 3'b111, 1'b0);
    end
    idle();
    compare_all("post_rst");

    tick(5);
    chk("side_signals", 64'(side_bad), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/raster_to_block.md
RASTER_TO_BLOCK -- requirements
Module: raster_to_block

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10: sample width per colour channel.
REQ-002 SHALL have parameter IMG_WIDTH, default 640: pixels per line, a multiple of 8 and at least 16.
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in, input, dctPort_t[3]: raster YCbCr samples from the colour converter; index 0=Y, 1=Cb, 2=Cr; pixel accepted when all three valid are 1.
REQ-006 SHALL have port sof, input, 1 bit: start of frame, qualified by an accepted pixel.
REQ-007 SHALL have port out, output, dctPort_t[3]: 8x8-block-ordered samples to the DCT, all three valid identical.
REQ-008 SHALL have port blk_first, output, 1 bit: marks sample (0,0) of each block.
REQ-009 SHALL have port blk_last, output, 1 bit: marks sample (7,7) of each block.

Function
REQ-010 SHALL hold two stripe banks per channel; a stripe is 8 lines x IMG_WIDTH samples.
REQ-011 SHALL write accepted pixels in raster order into the write bank at address row*IMG_WIDTH+col.
REQ-012 SHALL use a write counter: col 0..IMG_WIDTH-1, wrapping to 0 and incrementing row 0..7.
REQ-013 SHALL, when row=7 and col=IMG_WIDTH-1 are written (cycle T), mark the bank full, toggle the write bank and clear col/row.
REQ-014 SHALL use a read FSM with states IDLE and READ; IDLE->READ at T+1 when a full bank exists; READ->IDLE after 8*IMG_WIDTH reads unless the other bank is full, in which case it goes directly to READ of that bank with no gap.
REQ-015 SHALL, in READ, issue one read per cycle at address r*IMG_WIDTH + b*8 + c, with c 0..7 innermost, then r 0..7, then block b 0..IMG_WIDTH/8-1.
REQ-016 SHALL present the first out sample with valid=1 at cycle T+2 (address register plus 1-cycle RAM read); latency from the last write of a stripe is exactly 2 cycles.
REQ-017 SHALL keep out valid high continuously for 8*IMG_WIDTH cycles per stripe; data is don't-care when valid=0.
REQ-018 SHALL assert blk_first with c=0,r=0 and blk_last with c=7,r=7, aligned to the corresponding out sample.
REQ-019 SHALL clear the bank-full flag on the final read of that bank.
REQ-020 SHALL allow a write into a bank being read in the same cycle without corrupting unread data; this is guaranteed because input rate is at most 1 pixel/cycle.
REQ-021 SHALL, on an accepted pixel with sof=1, discard any partial stripe, write that pixel at row 0, col 0 of the current write bank, and leave any READ in progress unaffected.
REQ-022 SHALL ignore cycles where any in[i].valid is 0: no write and no counter change.

Reset
REQ-023 SHALL, on rst_n=0, immediately clear all out valid, blk_first and blk_last, the counters and the full flags, set the write bank to 0 and the FSM to IDLE; RAM contents are not reset.
REQ-024 SHALL, on reset mid-stripe or mid-READ, abandon the stripe and emit no further samples from it.

Structure
REQ-025 SHALL take dctPort_t (data, valid) from the shared interface definitions; BLK_SIZE=8 and the FSM state enum SHALL live in the shared package jpeg_pkg.
REQ-026 SHALL instantiate sub-module stripe_ram: simple dual-port, 2*8*IMG_WIDTH x DATA_WIDTH, registered read, one instance per channel.

Verification (IMG_WIDTH=16)
REQ-027 SHALL cover: 128 contiguous pixels with Y=row*16+col -> out valid at 2 cycles after the 128th input; Y sequence 0..7,16..23,...,112..119, then 8..15,24..31,...
REQ-028 SHALL cover: the same stripe with valid low every other cycle -> identical out sequence, starting 2 cycles after the last accepted pixel.
REQ-029 SHALL cover: two stripes back-to-back -> 256 consecutive valid outputs with no gap; blk_first/blk_last each pulse 4 times.
REQ-030 SHALL cover: sof asserted at pixel 50 of a stripe -> first 49 pixels discarded; the stripe completes 128 pixels after the sof pixel.
REQ-031 SHALL cover: rst_n low for 1 cycle during output sample 70 -> out valid is 0 at once and no output follows until a new full stripe.
REQ-032 SHALL cover: Cb=Cr=512 and Y ramp -> Cb/Cr outputs are 512 in lock-step with Y.
